// File: rtl/ccgrcg_pkg.sv
// Shared constants, FSM state type and code functions
// for the ccgrcg 15-bit code decoder.
package ccgrcg_pkg;

    localparam int CODE_W = 15;
    localparam int DATA_W = 4;
    localparam int FIFO_W = DATA_W + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Bit k of the code word carries f(k+1).
    function automatic logic [CODE_W-1:0] ccgrcg_encode(
        input logic [DATA_W-1:0] d
    );
        logic [CODE_W-1:0] f;
        f[0]  = ~d[1];
        f[1]  = d[1];
        f[2]  = ~(d[0] & d[3]);
        f[3]  = d[1];
        f[4]  = ~d[1] & ~d[2];
        f[5]  = d[3];
        f[6]  = d[3];
        f[7]  = d[3];
        f[8]  = ~(d[0] ^ d[1]);
        f[9]  = d[0];
        f[10] = d[0] | d[3];
        f[11] = ~(d[0] & d[2]);
        f[12] = d[2];
        f[13] = ~d[0] & ~d[3];
        f[14] = d[2];
        return f;
    endfunction

    // x1 and x3 are voted from their redundant copies.
    function automatic logic [DATA_W-1:0] ccgrcg_recover(
        input logic [CODE_W-1:0] c
    );
        logic [DATA_W-1:0] x;
        x[0] = c[9];
        x[1] = maj3(c[1], c[3], ~c[0]);
        x[2] = c[12];
        x[3] = maj3(c[5], c[6], c[7]);
        return x;
    endfunction

endpackage

// File: rtl/ccgrcg_out_fifo.sv
// Two-entry output FIFO; the head register drives
// the outputs directly so there is no read mux.
module ccgrcg_out_fifo
    import ccgrcg_pkg::*;
#(
    parameter int W = FIFO_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_valid,
    output logic [1:0]   o_cnt
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign w_push  = i_push && (r_cnt != 2'd2);
    assign w_pop   = i_pop && (r_cnt != 2'd0);
    assign o_dout  = r_head;
    assign o_valid = (r_cnt != 2'd0);
    assign o_cnt   = r_cnt;

    // Head/tail shuffle; simultaneous push+pop keeps order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= i_din;
                    else               r_tail <= i_din;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    if (r_cnt == 2'd2) r_head <= r_tail;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry held.
                    r_head <= i_din;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ccgrcg_code_decoder.sv
// Decodes 15-bit code words to nibbles, flags words that
// fail re-encoding and halts after a run of errored words.
module ccgrcg_code_decoder
    import ccgrcg_pkg::*;
#(
    parameter int ERR_LIMIT = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              halted,
    input  logic              clear
);

    localparam logic [8:0] LIM = 9'(ERR_LIMIT);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [7:0]        r_consec;
    logic [7:0]        w_consec_nxt;
    logic [8:0]        w_consec_inc;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [DATA_W-1:0] w_recov;
    logic              w_err;
    logic              w_acc;
    logic              w_pop;
    logic [FIFO_W-1:0] w_head;
    logic [1:0]        w_cnt;

    assign w_recov = ccgrcg_recover(in_code);
    assign w_err   = (ccgrcg_encode(w_recov) != in_code);

    // Depends only on registered state, never on out_ready.
    assign in_ready = (r_state == ST_RUN) && (w_cnt != 2'd2);
    assign w_acc    = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    assign w_consec_inc = {1'b0, r_consec} + 9'd1;

    assign out_err  = w_head[DATA_W];
    assign out_data = w_head[DATA_W-1:0];
    assign err_cnt  = r_err_cnt;
    assign halted   = (r_state == ST_HALT);

    ccgrcg_out_fifo #(
        .W(FIFO_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_acc),
        .i_din  ({w_err, w_recov}),
        .i_pop  (w_pop),
        .o_dout (w_head),
        .o_valid(out_valid),
        .o_cnt  (w_cnt)
    );

    // State and consecutive-error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_consec <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_consec <= w_consec_nxt;
        end
    end

    // Next state: clear overrides any accepted word.
    always_comb begin
        w_state_nxt  = r_state;
        w_consec_nxt = r_consec;
        if (clear) begin
            w_state_nxt  = ST_RUN;
            w_consec_nxt = 8'd0;
        end else if (w_acc) begin
            if (w_err) begin
                w_consec_nxt = w_consec_inc[7:0];
                if (w_consec_inc >= LIM) w_state_nxt = ST_HALT;
            end else begin
                w_consec_nxt = 8'd0;
            end
        end
    end

    // Saturating total error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clear) begin
            r_err_cnt <= '0;
        end else if (w_acc && w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

endmodule
